// File: rtl/median_rank_if.sv
// median_rank_if: sample/result bundle for the median_rank block.
//   di_i    sample input, valid while dsi_i is high
//   dsi_i   frame strobe, high while samples are presented
//   rank_i  rank to extract, 0 = max, N-1 = min (only with MEDIAN_RANK_EN)
//   do_o    result value
//   dso_o   result valid, held until the next frame start
//   err_o   one-cycle pulse when a frame ends with fewer than N samples
// Modports: master drives samples and reads results; slave is the block.
interface median_rank_if #(
  parameter int SIZE = 8,
  parameter int N    = 9,
  parameter int RW   = $clog2(N)
);
  logic [SIZE-1:0] di_i;
  logic            dsi_i;
`ifdef MEDIAN_RANK_EN
  logic [RW-1:0]   rank_i;
`endif
  logic [SIZE-1:0] do_o;
  logic            dso_o;
  logic            err_o;

`ifdef MEDIAN_RANK_EN
  modport master (output di_i, dsi_i, rank_i, input do_o, dso_o, err_o);
  modport slave  (input di_i, dsi_i, rank_i, output do_o, dso_o, err_o);
`else
  modport master (output di_i, dsi_i, input do_o, dso_o, err_o);
  modport slave  (input di_i, dsi_i, output do_o, dso_o, err_o);
`endif
endinterface

// File: rtl/median_rank.sv
// median_rank: loads a sliding window of N samples serially, then finds the
// rank-th largest value (rank 0 = max) by repeated max-extraction passes over
// the window, one element per cycle. Result appears (r+1)*N cycles after the
// edge that samples the end of the frame.
// Ports:
//   clk_i  clock, all logic on the rising edge
//   rst_i  synchronous reset, active-high
//   bus    median_rank_if.slave (di_i, dsi_i, [rank_i], do_o, dso_o, err_o)
// Optional feature macro MEDIAN_RANK_EN: when defined, rank_i selects the rank
// (clamped to N-1) at the end of loading; otherwise the median (N-1)/2 is used.
//
// state  | meaning
// IDLE   | waiting for a frame, no valid result
// LOAD   | shifting samples in while dsi_i is high
// SCAN   | extraction passes over the window
// DONE   | result valid on do_o, waiting for the next frame
module median_rank #(
  parameter int SIZE = 8,
  parameter int N    = 9,
  parameter int RW   = $clog2(N)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  median_rank_if.slave  bus
);
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_SCAN = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [SIZE-1:0] win_q [N];
  logic [SIZE-1:0] win_d [N];
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    rem_q, rem_d;
  logic [IW-1:0]   i_q, i_d, p_q, p_d, bidx_q, bidx_d;
  logic [SIZE-1:0] best_q, best_d;
  logic            bvld_q, bvld_d;
  logic [SIZE-1:0] do_q, do_d;
  logic            dso_q, dso_d, err_q, err_d;
  logic [IW-1:0]   rank_sel;

`ifdef MEDIAN_RANK_EN
  logic [IW-1:0] r_q, r_d;
  assign rank_sel = r_q;
`else
  assign rank_sel = IW'((N - 1) / 2);
`endif

  // Candidate for this cycle's element: removed elements never win, and the
  // strict compare keeps the lowest index on ties.
  logic            take;
  logic [SIZE-1:0] cur_best;
  logic [IW-1:0]   cur_idx;

  assign take     = !rem_q[i_q] && (!bvld_q || (win_q[i_q] > best_q));
  assign cur_best = take ? win_q[i_q] : best_q;
  assign cur_idx  = take ? i_q : bidx_q;

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    i_d     = i_q;
    p_d     = p_q;
    bidx_d  = bidx_q;
    best_d  = best_q;
    bvld_d  = bvld_q;
    do_d    = do_q;
    dso_d   = dso_q;
    err_d   = 1'b0;
`ifdef MEDIAN_RANK_EN
    r_d     = r_q;
`endif
    if (bus.dsi_i) begin
      // Any state: a strobe shifts a sample in; outside LOAD it starts a frame
      // (this is also the abort path out of SCAN).
      win_d[0] = bus.di_i;
      for (int k = 1; k < N; k++) win_d[k] = win_q[k-1];
      if (state_q == S_LOAD) begin
        cnt_d = (cnt_q == CW'(N)) ? cnt_q : cnt_q + CW'(1);
      end else begin
        cnt_d   = CW'(1);
        dso_d   = 1'b0;
        state_d = S_LOAD;
      end
    end else begin
      case (state_q)
        S_LOAD: begin
          if (cnt_q == CW'(N)) begin
            state_d = S_SCAN;
            rem_d   = '0;
            p_d     = '0;
            i_d     = '0;
            bvld_d  = 1'b0;
`ifdef MEDIAN_RANK_EN
            r_d = (bus.rank_i > RW'(N - 1)) ? IW'(N - 1) : IW'(bus.rank_i);
`endif
          end else begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end
        end
        S_SCAN: begin
          if (i_q == IW'(N - 1)) begin
            if (p_q == rank_sel) begin
              do_d    = cur_best;
              dso_d   = 1'b1;
              state_d = S_DONE;
            end else begin
              rem_d[cur_idx] = 1'b1;
              p_d    = p_q + IW'(1);
              i_d    = '0;
              bvld_d = 1'b0;
            end
          end else begin
            i_d    = i_q + IW'(1);
            best_d = cur_best;
            bidx_d = cur_idx;
            bvld_d = bvld_q | take;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      for (int k = 0; k < N; k++) win_q[k] <= '0;
      cnt_q  <= '0;
      rem_q  <= '0;
      i_q    <= '0;
      p_q    <= '0;
      bidx_q <= '0;
      best_q <= '0;
      bvld_q <= 1'b0;
      do_q   <= '0;
      dso_q  <= 1'b0;
      err_q  <= 1'b0;
`ifdef MEDIAN_RANK_EN
      r_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      i_q     <= i_d;
      p_q     <= p_d;
      bidx_q  <= bidx_d;
      best_q  <= best_d;
      bvld_q  <= bvld_d;
      do_q    <= do_d;
      dso_q   <= dso_d;
      err_q   <= err_d;
`ifdef MEDIAN_RANK_EN
      r_q     <= r_d;
`endif
    end
  end

  assign bus.do_o  = do_q;
  assign bus.dso_o = dso_q;
  assign bus.err_o = err_q;
endmodule

// File: tb/tb_median_rank.sv
// tb_median_rank: drives directed and random frames into median_rank and
// compares every cycle against a queue-and-sort reference of the window.
module tb_median_rank;
  localparam int SIZE = 8;
  localparam int N    = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  median_rank_if #(.SIZE(SIZE), .N(N)) bus ();
  median_rank #(.SIZE(SIZE), .N(N)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Reference: the window is the last N samples of the frame; the answer is
  // the r-th entry of the window sorted high-to-low, due (r+1)*N edges after
  // the edge that sees the strobe drop.
  int win[$];
  int srt[$];
  int mode = 0;           // 0 idle, 1 loading, 2 computing, 3 result held
  int timer = 0;
  int res = 0;
  int rk = 0;
  int exp_do = 0;
  bit exp_dso = 1'b0;
  bit exp_err = 1'b0;
  bit armed = 1'b0;
  int c0_cyc = 0;
  int rise_cyc = 0;
  bit prev_dso = 1'b0;
  int err_cnt = 0;

  function automatic int model_rank();
`ifdef MEDIAN_RANK_EN
    int m;
    m = int'(bus.rank_i);
    if (m > N - 1) m = N - 1;
    return m;
`else
    return (N - 1) / 2;
`endif
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      win.delete();
      mode = 0; exp_do = 0; exp_dso = 1'b0; exp_err = 1'b0; armed = 1'b1;
    end else begin
      exp_err = 1'b0;
      if (bus.dsi_i) begin
        if (mode != 1) begin
          win.delete();
          mode = 1;
          exp_dso = 1'b0;
        end
        win.push_front(int'(bus.di_i));
        if (win.size() > N) void'(win.pop_back());
      end else if (mode == 1) begin
        if (win.size() == N) begin
          srt = win;
          srt.sort();
          rk = model_rank();
          res = srt[N-1-rk];
          timer = (rk + 1) * N;
          mode = 2;
          c0_cyc = cyc;
        end else begin
          exp_err = 1'b1;
          mode = 0;
        end
      end else if (mode == 2) begin
        timer--;
        if (timer == 0) begin
          exp_do = res;
          exp_dso = 1'b1;
          mode = 3;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      vectors++;
      if (bus.do_o !== SIZE'(exp_do) || bus.dso_o !== exp_dso || bus.err_o !== exp_err) begin
        miscompares++;
        $display("FAIL cycle %0d outputs: do=%0h dso=%0b err=%0b required do=%0h dso=%0b err=%0b",
                 cyc, bus.do_o, bus.dso_o, bus.err_o, exp_do, exp_dso, exp_err);
      end
      if (bus.dso_o === 1'b1 && !prev_dso) rise_cyc = cyc;
      prev_dso = (bus.dso_o === 1'b1);
      if (bus.err_o === 1'b1) err_cnt++;
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input bit s, input int v);
    @(posedge clk);
    #2;
    bus.dsi_i = s;
    bus.di_i  = SIZE'(v);
  endtask

  task automatic send(input int vals[$]);
    foreach (vals[k]) drive(1'b1, vals[k]);
    drive(1'b0, 0);
  endtask

  task automatic wait_done(input string nm, input int budget);
    int n = 0;
    while (bus.dso_o !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (bus.dso_o !== 1'b1) check({nm, "_timeout"}, 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic frame_check(input string nm, input int vals[$], input int exp_v, input int lat);
    send(vals);
    wait_done(nm, lat + 40);
    check({nm, "_do"}, int'(bus.do_o), exp_v);
    check({nm, "_latency"}, rise_cyc - c0_cyc, lat);
  endtask

  int e0;
  int len;
  int gap;
  int q[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.dsi_i = 1'b0;
    bus.di_i  = '0;
`ifdef MEDIAN_RANK_EN
    bus.rank_i = 4'd4;
`endif
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("reset_do", int'(bus.do_o), 0);
    check("reset_dso", int'(bus.dso_o), 0);
    check("reset_err", int'(bus.err_o), 0);

    e0 = err_cnt;
    frame_check("median", '{3, 9, 1, 7, 5, 2, 8, 4, 6}, 5, 45);
    check("median_no_err", err_cnt - e0, 0);

    frame_check("ties_7", '{7, 7, 7, 7, 7, 7, 7, 7, 7}, 7, 45);
    frame_check("ties_29", '{2, 2, 2, 2, 9, 9, 9, 9, 9}, 9, 45);

    e0 = err_cnt;
    send('{1, 2, 3, 4, 5});
    repeat (8) @(negedge clk);
    check("short_err_pulses", err_cnt - e0, 1);
    check("short_dso", int'(bus.dso_o), 0);
    frame_check("after_short", '{3, 9, 1, 7, 5, 2, 8, 4, 6}, 5, 45);

    frame_check("sliding", '{10, 20, 30, 1, 2, 3, 4, 5, 6, 7, 8, 9}, 5, 45);

    send('{1, 2, 3, 4, 5, 6, 7, 8, 9});
    repeat (20) @(posedge clk);
    drive(1'b1, 255);
    @(negedge clk);
    check("abort_dso", int'(bus.dso_o), 0);
    frame_check("abort_new", '{255, 255, 255, 255, 255, 255, 255, 255}, 255, 45);

`ifdef MEDIAN_RANK_EN
    bus.rank_i = 4'd0;
    frame_check("rank0", '{1, 2, 3, 4, 5, 6, 7, 8, 9}, 9, 9);
    bus.rank_i = 4'd8;
    frame_check("rank8", '{1, 2, 3, 4, 5, 6, 7, 8, 9}, 1, 81);
    bus.rank_i = 4'd15;
    frame_check("rank15", '{1, 2, 3, 4, 5, 6, 7, 8, 9}, 1, 81);
    bus.rank_i = 4'd4;
`endif

    send('{9, 8, 7, 6, 5, 4, 3, 2, 1});
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("rst_scan_do", int'(bus.do_o), 0);
    check("rst_scan_dso", int'(bus.dso_o), 0);
    repeat (60) @(negedge clk);
    check("rst_scan_quiet", int'(bus.dso_o), 0);

    for (int f = 0; f < 40; f++) begin
`ifdef MEDIAN_RANK_EN
      bus.rank_i = 4'($urandom_range(0, 15));
`endif
      len = $urandom_range(2, 14);
      q.delete();
      for (int k = 0; k < len; k++)
        q.push_back((f % 3 == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 255)));
      send(q);
      gap = $urandom_range(0, 100);
      repeat (gap) @(posedge clk);
      if ($urandom_range(0, 19) == 0) begin
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
      end
    end
    repeat (100) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
